// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets, access size codes and byte-lane helpers.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFS        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFS = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFS = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFS    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFS    = 16'hBFFC;

  localparam int unsigned SIZE_BYTE = 1;
  localparam int unsigned SIZE_HALF = 2;
  localparam int unsigned SIZE_WORD = 4;

  typedef struct packed {
    logic       ok;
    logic [3:0] be;
  } lane_t;

  // Illegal sizes and misaligned accesses come back with ok=0 and no lanes enabled.
  function automatic lane_t lane_check(input int unsigned size, input logic [1:0] lo);
    lane_t r;
    r.ok = 1'b0;
    r.be = 4'b0000;
    case (size)
      SIZE_BYTE: begin r.ok = 1'b1; r.be = 4'b0001 << lo; end
      SIZE_HALF: if (!lo[0]) begin r.ok = 1'b1; r.be = 4'b0011 << lo; end
      SIZE_WORD: if (lo == 2'b00) begin r.ok = 1'b1; r.be = 4'b1111; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] mask,
                                        input logic [31:0] wdat);
    return (old & ~mask) | (wdat & mask);
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// mtime tick source. With CLINT_PRESCALER_EN a modulo-DIV counter emits a one-cycle tick,
// otherwise mtime advances on every clock.
module clint_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

`ifdef CLINT_PRESCALER_EN
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  localparam int unsigned unused_div = DIV;
  logic unused_clk;
  assign unused_clk = clk ^ rst_n;
  assign tick_o     = 1'b1;
`endif

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and free-running mtime behind the bus CLINT port.
// Define CLINT_PRESCALER_EN to advance mtime once every MTIME_DIV clocks.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SIZE_WIDTH     = 3,
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned MTIME_DIV      = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
  input  logic                      bus_clint_rd,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
  input  logic [REG_DATA_WIDTH-1:0] bus_clint_data,
  input  logic                      bus_clint_wr,
  output logic [BUS_DATA_WIDTH-1:0] clint_bus_data,
  output logic                      clint_timer_irq,
  output logic                      clint_software_irq,
  output logic [63:0]               clint_mtime
);

  logic [63:0]               mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic                      msip_q, msip_d;
  logic [BUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      tick;

  clint_tick_gen #(.DIV(MTIME_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  logic [15:0] rofs, wofs, rword_ofs, wword_ofs;
  lane_t       rl, wl;
  logic [31:0] wdat, wmask, rword, rval;
  logic        wen, w_msip, w_cmp_lo, w_cmp_hi, w_mt_lo, w_mt_hi;
  logic        unused_addr;

  assign rofs        = bus_clint_read_addr[15:0];
  assign wofs        = bus_clint_write_addr[15:0];
  assign unused_addr = ^{bus_clint_read_addr[ADDR_WIDTH-1:16], bus_clint_write_addr[ADDR_WIDTH-1:16]};
  assign rword_ofs   = {rofs[15:2], 2'b00};
  assign wword_ofs   = {wofs[15:2], 2'b00};
  assign rl          = lane_check(32'(bus_clint_read_size), rofs[1:0]);
  assign wl          = lane_check(32'(bus_clint_write_size), wofs[1:0]);

  // Write data is LSB-aligned on the bus; move it up to its byte lanes within the word.
  assign wdat  = 32'(bus_clint_data) << {wofs[1:0], 3'b000};
  assign wmask = byte_mask(wl.be);
  assign wen   = bus_clint_wr & wl.ok;

  assign w_msip   = wen && (wword_ofs == CLINT_MSIP_OFS);
  assign w_cmp_lo = wen && (wword_ofs == CLINT_MTIMECMP_LO_OFS);
  assign w_cmp_hi = wen && (wword_ofs == CLINT_MTIMECMP_HI_OFS);
  assign w_mt_lo  = wen && (wword_ofs == CLINT_MTIME_LO_OFS);
  assign w_mt_hi  = wen && (wword_ofs == CLINT_MTIME_HI_OFS);

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;
    if (w_msip && wmask[0]) msip_d = wdat[0];
    if (w_cmp_lo) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0],  wmask, wdat);
    if (w_cmp_hi) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wmask, wdat);
    // A write to either mtime half wins over that cycle's tick.
    if (w_mt_lo || w_mt_hi) begin
      if (w_mt_lo) mtime_d[31:0]  = merge(mtime_q[31:0],  wmask, wdat);
      if (w_mt_hi) mtime_d[63:32] = merge(mtime_q[63:32], wmask, wdat);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    rword = '0;
    case (rword_ofs)
      CLINT_MSIP_OFS:        rword = {31'b0, msip_q};
      CLINT_MTIMECMP_LO_OFS: rword = mtimecmp_q[31:0];
      CLINT_MTIMECMP_HI_OFS: rword = mtimecmp_q[63:32];
      CLINT_MTIME_LO_OFS:    rword = mtime_q[31:0];
      CLINT_MTIME_HI_OFS:    rword = mtime_q[63:32];
      default:               rword = '0;
    endcase
    // Rejected accesses have no lanes enabled, so they read as zero.
    rval    = (rword & byte_mask(rl.be)) >> {rofs[1:0], 3'b000};
    rdata_d = bus_clint_rd ? BUS_DATA_WIDTH'(rval) : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
    end
  end

  assign clint_bus_data     = rdata_q;
  assign clint_mtime        = mtime_q;
  assign clint_timer_irq    = (mtime_q >= mtimecmp_q);
  assign clint_software_irq = msip_q;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: byte-addressed reference model compared every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_clint;

  localparam int unsigned DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bus_clint_read_addr = '0;
  logic [2:0]  bus_clint_read_size = '0;
  logic        bus_clint_rd = 1'b0;
  logic [31:0] bus_clint_write_addr = '0;
  logic [2:0]  bus_clint_write_size = '0;
  logic [31:0] bus_clint_data = '0;
  logic        bus_clint_wr = 1'b0;
  logic [63:0] clint_bus_data;
  logic        clint_timer_irq;
  logic        clint_software_irq;
  logic [63:0] clint_mtime;

  clint #(.MTIME_DIV(DIV)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bus_clint_read_addr  (bus_clint_read_addr),
    .bus_clint_read_size  (bus_clint_read_size),
    .bus_clint_rd         (bus_clint_rd),
    .bus_clint_write_addr (bus_clint_write_addr),
    .bus_clint_write_size (bus_clint_write_size),
    .bus_clint_data       (bus_clint_data),
    .bus_clint_wr         (bus_clint_wr),
    .clint_bus_data       (clint_bus_data),
    .clint_timer_irq      (clint_timer_irq),
    .clint_software_irq   (clint_software_irq),
    .clint_mtime          (clint_mtime)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the register file seen as a byte-addressed space.
  logic [63:0] m_time, m_cmp, m_rdata;
  logic        m_msip;
  int unsigned m_cnt;

  function automatic logic [7:0] mget(input int unsigned o);
    if (o == 0) return {7'b0, m_msip};
    if (o >= 32'h4000 && o < 32'h4008) return m_cmp[8*(o-32'h4000) +: 8];
    if (o >= 32'hBFF8 && o < 32'hC000) return m_time[8*(o-32'hBFF8) +: 8];
    return 8'h00;
  endfunction

  function automatic bit mset(input int unsigned o, input logic [7:0] b);
    if (o == 0) m_msip = b[0];
    else if (o >= 32'h4000 && o < 32'h4008) m_cmp[8*(o-32'h4000) +: 8] = b;
    else if (o >= 32'hBFF8 && o < 32'hC000) begin
      m_time[8*(o-32'hBFF8) +: 8] = b;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_ok(input int unsigned sz, input int unsigned o);
    return (sz == 1) || (sz == 2 && o % 2 == 0) || (sz == 4 && o % 4 == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_time = 64'd0; m_cmp = '1; m_msip = 1'b0; m_rdata = 64'd0; m_cnt = 0;
    end else begin
      logic [31:0] rv;
      bit          hit, tk;
      int unsigned ro, wo, rs, ws;
      ro = bus_clint_read_addr[15:0];  rs = bus_clint_read_size;
      wo = bus_clint_write_addr[15:0]; ws = bus_clint_write_size;
      rv = 32'd0;
      if (bus_clint_rd && m_ok(rs, ro))
        for (int i = 0; i < int'(rs); i++) rv = rv | (32'(mget(ro + i)) << (8*i));
      hit = 1'b0;
      if (bus_clint_wr && m_ok(ws, wo))
        for (int i = 0; i < int'(ws); i++) hit = hit | mset(wo + i, bus_clint_data[8*i +: 8]);
`ifdef CLINT_PRESCALER_EN
      tk = (m_cnt == DIV - 1);
      m_cnt = tk ? 0 : m_cnt + 1;
`else
      tk = 1'b1;
`endif
      if (!hit && tk) m_time = m_time + 64'd1;
      if (bus_clint_rd) m_rdata = {32'd0, rv};
    end
  end

  always @(negedge clk) begin
    chk("mtime",   clint_mtime,        m_time);
    chk("timer",   clint_timer_irq,    m_time >= m_cmp);
    chk("sw_irq",  clint_software_irq, m_msip);
    chk("rdata",   clint_bus_data,     m_rdata);
  end

  // One bus cycle: drive strobes, let one posedge pass, land at posedge+1.
  task automatic bus(input logic rd, input logic [31:0] ra, input int rs,
                     input logic wr, input logic [31:0] wa, input int ws, input logic [31:0] wd);
    bus_clint_rd = rd; bus_clint_read_addr = ra; bus_clint_read_size = rs[2:0];
    bus_clint_wr = wr; bus_clint_write_addr = wa; bus_clint_write_size = ws[2:0];
    bus_clint_data = wd;
    @(posedge clk); #1;
    bus_clint_rd = 1'b0; bus_clint_wr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input int s, input logic [31:0] d);
    bus(1'b0, 32'h0, 4, 1'b1, a, s, d);
  endtask

  task automatic rd(input logic [31:0] a, input int s);
    bus(1'b1, a, s, 1'b0, 32'h0, 4, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0:       a = $urandom_range(0, 7);
      1:       a = 32'h4000 + $urandom_range(0, 7);
      2:       a = 32'hBFF8 + $urandom_range(0, 7);
      3:       a = $urandom;
      default: a = 32'h8000;
    endcase
    a[31:16] = 16'($urandom);
    return a;
  endfunction

  initial begin
    int n;
    int sizes[8] = '{1, 2, 4, 4, 1, 2, 0, 3};
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sizes[8] = '{1, 2, 4, 4, 1, 2, 0, 3};
    logic [63:0] exp_ticks;

    // Reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mtime", clint_mtime, 64'd0);
    chk("rst_timer", clint_timer_irq, 1'b0);
    chk("rst_sw",    clint_software_irq, 1'b0);
    chk("rst_rdata", clint_bus_data, 64'd0);
    rst_n = 1'b1;

    // Free-running tick
    repeat (100) @(posedge clk);
    #1;
`ifdef CLINT_PRESCALER_EN
    exp_ticks = 64'd10;
`else
    exp_ticks = 64'd100;
`endif
    chk("tick100", clint_mtime, exp_ticks);
    rd(32'h4000, 4); chk("cmp_lo_rst", clint_bus_data, 64'hFFFF_FFFF);
    rd(32'h4004, 4); chk("cmp_hi_rst", clint_bus_data, 64'hFFFF_FFFF);

    // Timer IRQ
    wr(32'hBFF8, 4, 32'd0);
    wr(32'h4004, 4, 32'd0);
    wr(32'h4000, 4, 32'd50);
    n = 0;
    while (clint_mtime < 64'd50 && n < 2000) begin
      if (clint_mtime == 64'd49) chk("irq_before", clint_timer_irq, 1'b0);
      @(posedge clk); #1; n++;
    end
    chk("mtime_at50", clint_mtime, 64'd50);
    chk("irq_at50",   clint_timer_irq, 1'b1);
    wr(32'h4000, 4, 32'hFFFF_FFFF);
    chk("irq_fall", clint_timer_irq, 1'b0);

    // Same-cycle read and write of one register: read sees the old value
    bus(1'b1, 32'h4000, 4, 1'b1, 32'h4000, 4, 32'h0000_1234);
    chk("rw_old", clint_bus_data, 64'hFFFF_FFFF);
    rd(32'h4000, 4); chk("rw_new", clint_bus_data, 64'h1234);
    wr(32'h4000, 4, 32'hFFFF_FFFF);

    // Sub-word access
    wr(32'hBFF8, 4, 32'h0000_1000);
    wr(32'hBFF9, 1, 32'h0000_00AB);
    rd(32'hBFF8, 4); chk("byte_wr", clint_bus_data, 64'h0000_AB00);
    wr(32'hBFF8, 4, 32'h1234_5678);
    rd(32'hBFFA, 2); chk("half_rd", clint_bus_data, 64'h1234);
    wr(32'hBFF9, 2, 32'h0000_FFFF);
    rd(32'hBFF9, 2); chk("mis_rd", clint_bus_data, 64'd0);
    rd(32'h4001, 4); chk("mis_rd4", clint_bus_data, 64'd0);

    // 64-bit wrap
    wr(32'hBFFC, 4, 32'hFFFF_FFFF);
    wr(32'hBFF8, 4, 32'hFFFF_FFFE);
    chk("wrap_pre", clint_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    n = 0;
    while (clint_mtime != 64'd0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("wrap_zero", clint_mtime, 64'd0);
    chk("wrap_irq",  clint_timer_irq, 1'b0);

    // msip and read latency
    wr(32'h0000, 4, 32'hFFFF_FFFF);
    chk("sw_set", clint_software_irq, 1'b1);
    rd(32'h0000, 4); chk("msip_rd", clint_bus_data, 64'h1);
    rd(32'h8000, 4); chk("hole_rd", clint_bus_data, 64'd0);
    rd(32'h0000, 4); chk("msip_rd2", clint_bus_data, 64'h1);

    // Reset in the middle of a read drops it and clears the output immediately
    bus_clint_rd = 1'b1; bus_clint_read_addr = 32'h0; bus_clint_read_size = 3'd4;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rdata", clint_bus_data, 64'd0);
    chk("rst_mid_sw",    clint_software_irq, 1'b0);
    bus_clint_rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      bus($urandom_range(0, 1) == 1, rand_addr(), sizes[$urandom_range(0, 7)],
          $urandom_range(0, 2) == 0, rand_addr(), sizes[$urandom_range(0, 7)], $urandom);
    end
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
